// File: rtl/serial_bus_pkg.sv
// Shared definitions for the serial bus: frame widths, bus_mode encodings,
// the initiator transmit state type and the target address map that the
// bus address decoder uses. The decoder selects a target from the top two
// address bits; sel=2'b11 has no target, so nobody acknowledges it.
package serial_bus_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 8;

  localparam logic MODE_ADDR = 1'b0;
  localparam logic MODE_DATA = 1'b1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARB      = 3'd1,
    ADDR     = 3'd2,
    ACK_WAIT = 3'd3,
    DATA     = 3'd4,
    DONE     = 3'd5
  } tx_state_t;

  // Address map: target select field is addr[SEL_MSB:SEL_LSB].
  localparam int         SEL_MSB      = 15;
  localparam int         SEL_LSB      = 14;
  localparam logic [1:0] SEL_TGT1     = 2'b00;
  localparam logic [1:0] SEL_TGT2     = 2'b01;
  localparam logic [1:0] SEL_TGT3     = 2'b10;
  localparam logic [1:0] SEL_UNMAPPED = 2'b11;

  function automatic logic [1:0] addr_sel(input logic [ADDR_W_DEF-1:0] addr);
    return addr[SEL_MSB:SEL_LSB];
  endfunction

  function automatic logic addr_mapped(input logic [ADDR_W_DEF-1:0] addr);
    return addr_sel(addr) != SEL_UNMAPPED;
  endfunction

endpackage

// File: rtl/serial_init_tx_if.sv
// Signal bundle of the serial initiator transmitter.
// Request port handshake: a request transfers on a rising clock edge where
// req_valid && req_ready are both high; req_addr/req_wdata are sampled on
// that edge only. req_valid is ignored while req_ready is low, and the
// initiator may change or drop it freely in those cycles.
// Bus side: bus_req/bus_grant with the arbiter, serial bit stream
// (bus_data_out qualified by bus_data_out_valid, bus_mode selects address or
// data phase), target_ack from the decoder, done/err completion pulses.
// dbg_state exposes the transmit FSM state for observation.
// Modports: slave = the transmitter block, master = the initiator/environment.
interface serial_init_tx_if
  import serial_bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              bus_req;
  logic              bus_grant;
  logic              bus_data_out;
  logic              bus_data_out_valid;
  logic              bus_mode;
  logic              target_ack;
  logic              done;
  logic              err;
  tx_state_t         dbg_state;

  modport slave (
    input  req_valid, req_addr, req_wdata, bus_grant, target_ack,
    output req_ready, bus_req, bus_data_out, bus_data_out_valid, bus_mode,
           done, err, dbg_state
  );

  modport master (
    output req_valid, req_addr, req_wdata, bus_grant, target_ack,
    input  req_ready, bus_req, bus_data_out, bus_data_out_valid, bus_mode,
           done, err, dbg_state
  );

endinterface

// File: rtl/serial_init_tx_piso_shifter.sv
// Parallel-in serial-out shift register, LSB first.
// Ports: clk, rst (sync, active high), load (load_data into register, has
// priority over shift), shift (move one bit towards bit 0, zero fill),
// load_data, bit_out (current LSB).
module piso_shifter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] load_data,
  output logic             bit_out
);

  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;

  always_comb begin
    shift_d = shift_q;
    if (load) begin
      shift_d = load_data;
    end else if (shift) begin
      shift_d = {1'b0, shift_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

  assign bit_out = shift_q[0];

endmodule

// File: rtl/serial_init_tx.sv
// Initiator-side serial transmitter. Accepts a parallel write request,
// arbitrates for the bus, shifts the address out LSB first (bus_mode=0),
// waits for a target acknowledge, then shifts the write data out LSB first
// (bus_mode=1). Aborts with an err pulse on acknowledge timeout or on loss
// of grant; signals a successful transfer with a done pulse.
// Ports: clk, rst (sync, active high), bif (serial_init_tx_if.slave: request
// port, arbiter handshake, serial output, target_ack, done/err, dbg_state).
module serial_init_tx
  import serial_bus_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic               clk,
  input  logic               rst,
  serial_init_tx_if.slave    bif
);

  localparam int SHIFT_W   = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int BIT_CNT_W = $clog2(SHIFT_W);
  localparam int TO_CNT_W  = $clog2(ACK_TIMEOUT + 1);

  tx_state_t            state_q, state_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [TO_CNT_W-1:0]  to_cnt_q, to_cnt_d;
  logic [TO_CNT_W-1:0]  to_cnt_inc;
  logic [DATA_W-1:0]    wdata_q, wdata_d;

  logic               sh_load;
  logic               sh_shift;
  logic [SHIFT_W-1:0] sh_data;
  logic               sh_bit;

  logic req_ready;
  logic bus_req;
  logic data_out;
  logic data_out_valid;
  logic mode;
  logic done;
  logic err;

  // One shifter serves both phases: loaded with the address on acceptance,
  // reloaded with the held write data when the target acknowledges.
  piso_shifter #(.WIDTH(SHIFT_W)) u_shifter (
    .clk       (clk),
    .rst       (rst),
    .load      (sh_load),
    .shift     (sh_shift),
    .load_data (sh_data),
    .bit_out   (sh_bit)
  );

  assign to_cnt_inc = to_cnt_q + TO_CNT_W'(1);

  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    to_cnt_d       = to_cnt_q;
    wdata_d        = wdata_q;
    sh_load        = 1'b0;
    sh_shift       = 1'b0;
    sh_data        = '0;
    req_ready      = 1'b0;
    bus_req        = 1'b0;
    data_out       = 1'b0;
    data_out_valid = 1'b0;
    mode           = MODE_ADDR;
    done           = 1'b0;
    err            = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (bif.req_valid) begin
          sh_load = 1'b1;
          sh_data = SHIFT_W'(bif.req_addr);
          wdata_d = DATA_W'(bif.req_wdata);
          state_d = ARB;
        end
      end

      ARB: begin
        bus_req = 1'b1;
        if (bif.bus_grant) begin
          state_d = ADDR;
        end
      end

      ADDR: begin
        bus_req = 1'b1;
        if (!bif.bus_grant) begin
          err     = 1'b1;
          state_d = IDLE;
        end else begin
          data_out       = sh_bit;
          data_out_valid = 1'b1;
          sh_shift       = 1'b1;
          if (bit_cnt_q == BIT_CNT_W'(ADDR_W - 1)) begin
            state_d = ACK_WAIT;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          end
        end
      end

      ACK_WAIT: begin
        bus_req = 1'b1;
        if (!bif.bus_grant) begin
          err     = 1'b1;
          state_d = IDLE;
        end else if (bif.target_ack) begin
          // An ack in the final waiting cycle still wins over the timeout.
          sh_load = 1'b1;
          sh_data = SHIFT_W'(wdata_q);
          state_d = DATA;
        end else if (to_cnt_inc == TO_CNT_W'(ACK_TIMEOUT)) begin
          err     = 1'b1;
          state_d = IDLE;
        end else begin
          to_cnt_d = to_cnt_inc;
        end
      end

      DATA: begin
        bus_req = 1'b1;
        mode    = MODE_DATA;
        if (!bif.bus_grant) begin
          err     = 1'b1;
          state_d = IDLE;
        end else begin
          data_out       = sh_bit;
          data_out_valid = 1'b1;
          sh_shift       = 1'b1;
          if (bit_cnt_q == BIT_CNT_W'(DATA_W - 1)) begin
            state_d = DONE;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          end
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Every state starts with fresh counters.
    if (state_d != state_q) begin
      bit_cnt_d = '0;
      to_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      to_cnt_q  <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      to_cnt_q  <= to_cnt_d;
      wdata_q   <= wdata_d;
    end
  end

  assign bif.req_ready          = req_ready;
  assign bif.bus_req            = bus_req;
  assign bif.bus_data_out       = data_out;
  assign bif.bus_data_out_valid = data_out_valid;
  assign bif.bus_mode           = mode;
  assign bif.done               = done;
  assign bif.err                = err;
  assign bif.dbg_state          = state_q;

endmodule

// File: tb/tb_serial_init_tx.sv
// Bench for serial_init_tx. The environment plays initiator, arbiter and
// decoder/target. For each transfer a reference model derives, from the
// protocol rules, the per-cycle grant/ack drive and the expected outputs
// {req_ready, bus_req, valid, data, mode, done, err}; the run task compares
// every cycle against that expected queue.
module tb_serial_init_tx;
  import serial_bus_pkg::*;

  localparam int AW    = 16;
  localparam int DW    = 8;
  localparam int TO    = 8;
  localparam int OBS_W = 7;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_init_tx_if #(.ADDR_W(AW), .DATA_W(DW)) bif ();

  serial_init_tx #(.ADDR_W(AW), .DATA_W(DW), .ACK_TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bif (bif)
  );

  // ---------------- scoreboard state ----------------
  logic [OBS_W-1:0] exp_q[$];
  logic             grant_q[$];
  logic             ack_q[$];
  int               data_start;
  int               total = 0;
  int               bad   = 0;

  logic [AW-1:0] cap_addr;
  logic [DW-1:0] cap_data;
  int            cap_na;
  int            cap_nd;

  // field order: req_ready, bus_req, valid, data, mode, done, err
  function automatic logic [OBS_W-1:0] mk(input logic rr, input logic br,
      input logic v, input logic d, input logic m, input logic dn, input logic er);
    return {rr, br, v, d, m, dn, er};
  endfunction

  function automatic logic [OBS_W-1:0] observe();
    return {bif.req_ready, bif.bus_req, bif.bus_data_out_valid, bif.bus_data_out,
            bif.bus_mode, bif.done, bif.err};
  endfunction

  task automatic push(input logic [OBS_W-1:0] e, input logic g, input logic a);
    exp_q.push_back(e);
    grant_q.push_back(g);
    ack_q.push_back(a);
  endtask

  task automatic check_obs(input string tag, input int cyc, input logic [OBS_W-1:0] e);
    logic [OBS_W-1:0] o;
    o = observe();
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b (rr,br,v,d,m,done,err)",
             tag, cyc, o, e);
    end
  endtask

  task automatic check_val(input string tag, input int obs_v, input int exp_v);
    total++;
    assert (obs_v === exp_v) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs_v, exp_v);
    end
  endtask

  // Reference model of one transfer starting at its acceptance cycle.
  // gd: ARB cycles before grant; ack_lat: ACK_WAIT cycles before ack
  // (ignored for unmapped addresses); loss: -1 none, 0..AW-1 address bit,
  // AW..AW+DW-1 data bit at which grant is withdrawn.
  task automatic build(input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                       input int gd, input int ack_lat, input int loss);
    exp_q.delete(); grant_q.delete(); ack_q.delete();
    data_start = -1;
    push(mk(1, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0);
    for (int i = 0; i < gd; i++) push(mk(0, 1, 0, 0, 0, 0, 0), 1'b0, 1'b0);
    push(mk(0, 1, 0, 0, 0, 0, 0), 1'b1, 1'b0);
    for (int i = 0; i < AW; i++) begin
      if (loss == i) begin
        push(mk(0, 1, 0, 0, 0, 0, 1), 1'b0, 1'b0);
        return;
      end
      push(mk(0, 1, 1, addr[i], 0, 0, 0), 1'b1, 1'b0);
    end
    if (addr[15:14] == 2'b11) begin
      for (int i = 0; i < TO; i++) push(mk(0, 1, 0, 0, 0, 0, (i == TO - 1)), 1'b1, 1'b0);
      return;
    end
    for (int i = 0; i <= ack_lat; i++) push(mk(0, 1, 0, 0, 0, 0, 0), 1'b1, (i == ack_lat));
    data_start = exp_q.size();
    for (int i = 0; i < DW; i++) begin
      if (loss == AW + i) begin
        push(mk(0, 1, 0, 0, 1, 0, 1), 1'b0, 1'b1);
        return;
      end
      push(mk(0, 1, 1, wdata[i], 1, 0, 0), 1'b1, 1'b1);
    end
    push(mk(0, 0, 0, 0, 0, 1, 0), 1'b0, 1'b0);
  endtask

  // ---------------- driver ----------------
  // Called at posedge+1. Runs ncyc cycles of the model (or all if ncyc<0);
  // req_valid is noise after the acceptance cycle and must be ignored.
  task automatic run(input string tag, input logic [AW-1:0] addr,
                     input logic [DW-1:0] wdata, input int ncyc);
    int n;
    n = (ncyc < 0) ? exp_q.size() : ncyc;
    cap_addr = '0; cap_data = '0; cap_na = 0; cap_nd = 0;
    for (int c = 0; c < n; c++) begin
      if (c == 0) begin
        bif.req_valid = 1'b1;
        bif.req_addr  = addr;
        bif.req_wdata = wdata;
      end else begin
        bif.req_valid = 1'($urandom_range(0, 1));
        bif.req_addr  = AW'($urandom);
        bif.req_wdata = DW'($urandom);
      end
      bif.bus_grant  = grant_q[c];
      bif.target_ack = ack_q[c];
      #4;
      check_obs(tag, c, exp_q[c]);
      if (bif.bus_data_out_valid === 1'b1) begin
        if (bif.bus_mode === 1'b0 && cap_na < AW) begin
          cap_addr[cap_na] = bif.bus_data_out;
          cap_na++;
        end else if (bif.bus_mode === 1'b1 && cap_nd < DW) begin
          cap_data[cap_nd] = bif.bus_data_out;
          cap_nd++;
        end
      end
      @(posedge clk); #1;
    end
    bif.req_valid  = 1'b0;
    bif.bus_grant  = 1'b0;
    bif.target_ack = 1'b0;
  endtask

  task automatic idle_check(input string tag);
    bif.req_valid = 1'b0;
    #4;
    check_obs(tag, 0, mk(1, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;
    int            rloss;
    int            rack;

    rst = 1'b1;
    bif.req_valid = 1'b0; bif.req_addr = '0; bif.req_wdata = '0;
    bif.bus_grant = 1'b0; bif.target_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1; bif.req_valid = 1'b1; bif.bus_grant = 1'b1;
    #4;
    check_obs("reset_outputs", 0, mk(1, 0, 0, 0, 0, 0, 0));
    check_val("reset_state", int'(bif.dbg_state), int'(IDLE));
    @(posedge clk); #1;
    rst = 1'b0; bif.req_valid = 1'b0; bif.bus_grant = 1'b0;
    #4; @(posedge clk); #1;

    // nominal write
    build(16'h4123, 8'hA5, 0, 1, -1);
    run("nominal", 16'h4123, 8'hA5, -1);
    check_val("nominal_addr", int'(cap_addr), 16'h4123);
    check_val("nominal_sel", int'(cap_addr[15:14]), 1);
    check_val("nominal_data", int'(cap_data), 8'hA5);
    idle_check("nominal_idle");

    // unmapped address: timeout
    build(16'hC000, 8'h5A, 0, 0, -1);
    run("unmapped", 16'hC000, 8'h5A, -1);
    check_val("unmapped_nd", cap_nd, 0);
    idle_check("unmapped_idle");

    // grant arrives 3 cycles after acceptance
    build(16'h2468, 8'h3C, 2, 1, -1);
    run("delayed_grant", 16'h2468, 8'h3C, -1);
    check_val("delayed_addr", int'(cap_addr), 16'h2468);
    idle_check("delayed_idle");

    // grant lost on address bit 5
    build(16'h4123, 8'hA5, 0, 1, 5);
    run("grant_loss", 16'h4123, 8'hA5, -1);
    check_val("grant_loss_nbits", cap_na, 5);
    idle_check("grant_loss_idle");

    // back-to-back
    build(16'h0012, 8'h3C, 0, 0, -1);
    run("b2b_first", 16'h0012, 8'h3C, -1);
    check_val("b2b_first_data", int'(cap_data), 8'h3C);
    build(16'h8001, 8'hFF, 0, 1, -1);
    run("b2b_second", 16'h8001, 8'hFF, -1);
    check_val("b2b_second_sel", int'(cap_addr[15:14]), 2);
    check_val("b2b_second_data", int'(cap_data), 8'hFF);
    idle_check("b2b_idle");

    // reset while data bit 3 is on the bus
    build(16'h1234, 8'h96, 0, 1, -1);
    run("rst_mid", 16'h1234, 8'h96, data_start + 3);
    rst = 1'b1; bif.bus_grant = 1'b1; bif.target_ack = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; bif.bus_grant = 1'b0; bif.target_ack = 1'b0;
    #4;
    check_obs("rst_mid_after", 0, mk(1, 0, 0, 0, 0, 0, 0));
    check_val("rst_mid_state", int'(bif.dbg_state), int'(IDLE));
    @(posedge clk); #1;
    build(16'h1234, 8'h96, 0, 1, -1);
    run("rst_mid_fresh", 16'h1234, 8'h96, -1);
    check_val("rst_mid_fresh_data", int'(cap_data), 8'h96);
    idle_check("rst_mid_fresh_idle");

    // randomized transfers
    for (int t = 0; t < 40; t++) begin
      ra = AW'($urandom);
      rd = DW'($urandom);
      rloss = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, AW + DW - 1)) : -1;
      rack  = ($urandom_range(0, 7) == 0) ? TO - 1 : int'($urandom_range(0, 2));
      build(ra, rd, int'($urandom_range(0, 4)), rack, rloss);
      run("random", ra, rd, -1);
      if ($urandom_range(0, 1) == 1) idle_check("random_idle");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_init_tx.md
Name: serial_init_tx

Overview:
- Initiator-side serial transmitter for the serial bus.
- Accepts a parallel write request and requests the bus from the arbiter. Once granted, it shifts the address out LSB-first with bus_mode=0, waits for the addressed target to acknowledge, then shifts the write data out LSB-first with bus_mode=1.
- Sits between an initiator's parallel request port and the shared serial bus; it is the transmit end whose address phase the bus address decoder receives.

Parameters:
- ADDR_W, 16, address width in bits; must match the decoder's 16-bit address frame.
- DATA_W, 8, write-data width in bits.
- ACK_TIMEOUT, 8, cycles allowed in ACK_WAIT before abort; must be >= 1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_addr  in  ADDR_W  target address; captured when req_valid && req_ready.
- req_wdata  in  DATA_W  write data; captured with req_addr.
- bus_req  out  1  bus request to the arbiter.
- bus_grant  in  1  grant from the arbiter.
- bus_data_out  out  1  serial bit.
- bus_data_out_valid  out  1  bus_data_out carries a valid bit this cycle.
- bus_mode  out  1  0 = address phase, 1 = data phase.
- target_ack  in  1  OR of the decoder's target valids; high while a target is selected.
- done  out  1  one-cycle pulse: transfer completed successfully.
- err  out  1  one-cycle pulse: transfer aborted (timeout or grant loss).

Behaviour:
- Reset (rst=1 at a clock edge), from any state:
  - state becomes IDLE; shift register and counters clear.
  - req_ready=1; bus_req, bus_data_out, bus_data_out_valid, bus_mode, done and err are all 0 from the following cycle.
- IDLE:
  - req_ready=1.
  - On req_valid: latch addr/wdata into a shift register, clear bit_cnt, go to ARB.
- ARB:
  - bus_req=1 and stays 1 through ADDR, ACK_WAIT and DATA.
  - When bus_grant=1: go to ADDR. The first address bit appears in the cycle after grant is seen.
  - There is no timeout in ARB.
- ADDR:
  - Each cycle: bus_data_out = addr[bit_cnt], bus_data_out_valid=1, bus_mode=0.
  - After bit ADDR_W-1 is driven, go to ACK_WAIT.
  - Exactly ADDR_W contiguous valid cycles; no gaps.
- ACK_WAIT:
  - bus_data_out_valid=0, bus_mode=0, to_cnt increments each cycle.
  - target_ack=1: go to DATA with bit_cnt cleared. The decoder's pending-load gives 1–2 cycles of latency; this is tolerated.
  - to_cnt reaches ACK_TIMEOUT with no ack: pulse err, drop bus_req, go to IDLE. This covers an unmapped address.
- DATA:
  - Each cycle: bus_data_out = wdata[bit_cnt], bus_data_out_valid=1, bus_mode=1.
  - After bit DATA_W-1 is driven, go to DONE.
- DONE:
  - done=1 for exactly one cycle; bus_req=0; bus_data_out_valid=0. Next state is IDLE.
  - The target release is handled by bus/arbiter logic, not by this block.
- Grant loss: bus_grant=0 in ADDR, ACK_WAIT or DATA aborts that cycle.
  - bus_data_out_valid=0 that cycle, err pulses, bus_req drops, go to IDLE.
  - A partial address frame is left for the decoder's invalid-cycle clear.
- Output defaults: bus_mode holds 0 outside DATA. bus_data_out is 0 whenever bus_data_out_valid=0.
- Counters:
  - bit_cnt width is $clog2(max(ADDR_W,DATA_W)).
  - to_cnt width is $clog2(ACK_TIMEOUT+1).
  - Neither counter wraps; both are cleared on every state entry.
- Back-to-back requests:
  - The earliest new acceptance is the cycle after DONE, since IDLE lasts at least one cycle.
  - req_ready=0 in all non-IDLE states; req_valid is ignored there.
- done and err are mutually exclusive, and each lasts exactly one cycle.

Decomposition:
- Shared package serial_bus_pkg holds:
  - ADDR_W/DATA_W defaults;
  - MODE_ADDR=1'b0 and MODE_DATA=1'b1;
  - tx_state_t enum {IDLE, ARB, ADDR, ACK_WAIT, DATA, DONE};
  - the target address-map constants shared with the decoder.
- One sub-module, piso_shifter: parameterised-width, load/shift, LSB-first. It is instantiated once and reloaded at the ADDR-to-DATA transition.

Test Plan:
- Nominal write: addr=0x4123, wdata=0xA5, grant immediate, ack 2 cycles after the last address bit.
  - Required: 16 address bits LSB-first with mode=0, then bits 1,0,1,0,0,1,0,1 with mode=1.
  - done pulses once; the decoder under test selects target 2 (sel=01).
- Unmapped address: addr=0xC000, target_ack never asserted.
  - Required: err pulses exactly 8 cycles after the last address bit; no data bits are driven; bus_req=0 the next cycle.
- Delayed grant: bus_grant asserted 3 cycles after request acceptance.
  - Required: bus_req=1 throughout ARB; the first address bit appears the cycle after grant; no valid bits are driven before it.
- Grant loss: bus_grant dropped while address bit 5 is being driven.
  - Required: only 5 valid bits are seen, err pulses, IDLE is reached, and req_ready=1 the following cycle.
- Back-to-back: two requests, 0x0012/0x3C then 0x8001/0xFF.
  - Required: the second is accepted the cycle after DONE; the second frame decodes to target 3 (sel=10).
- Reset mid-DATA: rst asserted on data bit 3.
  - Required: the next cycle shows bus_req=0, bus_data_out_valid=0, done=0, err=0, req_ready=1; a fresh request then completes normally.
